datapath: RTL and testbench
===========================

# datapath

32-bit bus-based CPU datapath for the Phase 1 Mini-SRC processor. It contains sixteen general registers, HI/LO, PC, IR, MAR, MDR, Y, a 64-bit Z result register, an input-port register, a constant register C, a 32-bit ALU and a shared bus with a priority encoder. All sequencing comes from external per-cycle control strobes, supplied by a testbench now and by the control unit in later phases.

## Interface
- No parameters.
- clock  in  1  rising-edge clock for all registers.
- clear  in  1  reset; synchronous, active-low. Every register clears to 0 on a rising edge where clear=0.
- R0in..R15in  in  1 each  load general register Rn from the bus.
- HIin, LOin, PCin, IRin, MARin, Yin, In_Portin, Coutin  in  1 each  load the named register from the bus.
- Zhighin / Zlowin  in  1 each  load Z[63:32] / Z[31:0] from the bus.
- Zin  in  1  load the 64-bit ALU result into Z.
- MDRin  in  1  load MDR.
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
- R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout  in  1 each  drive the named register onto the bus.
- IncPC  in  1  forces the ALU result to bus+1.
- Mdatain  in  32  memory read data.
- ALU_Control  in  5  ALU operation select.
- Out_Portout  out  32  combinational mirror of the bus.

## Operation
- Registers: R0–R15, HI, LO, PC, IR, MAR, MDR, Y, In_Port and C are 32 bits; Z is 64 bits. General register instances are named R0..R15, each with state q (the bench probes DUT.R5.q).
- Each register loads on a rising edge when its in-strobe is 1. Otherwise it holds.
- Bus: a priority encoder selects one source. If several out-strobes are 1, the first in this order wins: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR, In_Port, C.
  - With no out-strobe asserted, the bus is 0.
- MDR input: Read ? Mdatain : bus.
- ALU: operand A = Y, operand B = bus. The result is 64 bits, written to Z only when Zin=1.
- For all non-MUL/DIV operations, result[63:32] = 0. ALU_Control codes:
  - 00000 ADD A+B
  - 00001 SUB A−B
  - 00010 AND
  - 00011 OR
  - 00100 SHR logical, by B[4:0]
  - 00101 SHRA arithmetic, by B[4:0]
  - 00110 SHL, by B[4:0]
  - 00111 ROR, by B[4:0]
  - 01000 ROL, by B[4:0]
  - 01001 MUL: signed A×B, 64-bit result, low word in Z[31:0]
  - 01010 DIV: signed; quotient in Z[31:0], remainder in Z[63:32]. Divide by zero gives quotient 0xFFFFFFFF and remainder A.
  - 01011 NEG −B
  - 01100 NOT ~B
  - Other codes give 0.
- IncPC=1 overrides ALU_Control: result = {32'b0, B+1}.
- Arithmetic wraps modulo 2^32; no carry or overflow flags.
- Out_Portout = bus at all times.

## Timing
- Register loads take effect on the same rising edge; the new value is visible on the bus in the next cycle. This gives one cycle of latency per register transfer.
- ALU and bus paths are combinational within a cycle. Y must be loaded in an earlier cycle than the Zin cycle.
- Reset: on a rising edge with clear=0, every register (R0–R15, HI, LO, PC, IR, MAR, MDR, Y, Z, In_Port, C) becomes 0.
  - Reset overrides any simultaneous load.
  - Out_Portout reads 0 while all sources are 0.
  - Reset mid-sequence discards partial results.
- Simultaneous in-strobes: all enabled destinations load the same bus value.
- Same register as both source and destination (e.g. R5out with R5in): the register captures its own old value.
- Zin together with Zhighin/Zlowin: Zin wins.

## Test plan
- Reset: clear=0 for one edge after arbitrary loads → all registers read 0 and Out_Portout=0.
- Register load (clear=1 throughout): Mdatain=0x34, Read, MDRin; then MDRout, R5in → R5=0x34. Repeat with 0x45 into R6 → R6=0x45.
- Fetch: PCout, MARin, IncPC, Zin with PC=0 → MAR=0, Z=1. Then Zlowout, PCin, Read, MDRin with Mdatain=0x112B0000 → PC=1, MDR=0x112B0000. Then MDRout, IRin → IR=0x112B0000.
- AND: R5out, Yin; then R6out, ALU_Control=00010, Zin; then Zlowout, R2in → R2=0x00000004.
- Arithmetic: Y=0xFFFFFFFF, B=1, ADD → Z=0x0000000000000000. MUL of Y=−2 and B=3 → Z=0xFFFFFFFFFFFFFFFA. DIV of 7 by −2 → quotient 0xFFFFFFFD, remainder 1.
- Priority and shifts: R1out and R3out together → bus = R1. ROR of 0x00000001 by 1 → 0x80000000. SHRA of 0x80000000 by 4 → 0xF8000000.

Source files
------------

// File: rtl/datapath.sv
// Mini-SRC Phase 1 datapath: shared 32-bit bus, register file, special
// registers, 64-bit Z and a combinational ALU. Sequencing comes from the
// per-cycle control strobes.

// One 32-bit bus register with load enable and synchronous active-low clear.
module dp_reg (
    input  logic        clock,
    input  logic        clear,
    input  logic        en,
    input  logic [31:0] d,
    output logic [31:0] q
);
    // Clear beats load; otherwise load on en, else hold.
    always_ff @(posedge clock) begin
        if (!clear)  q <= '0;
        else if (en) q <= d;
    end
endmodule

module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin, LOin, PCin, IRin, MARin, Yin, In_Portin, Coutin,
    input  logic        Zhighin, Zlowin, Zin, MDRin, Read,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout,
    input  logic        In_Portout, Coutout,
    input  logic        IncPC,
    input  logic [31:0] Mdatain,
    input  logic [4:0]  ALU_Control,
    output logic [31:0] Out_Portout
);
    logic [15:0] rin, rout;
    logic [31:0] r_q [16];
    logic [31:0] hi_q, lo_q, pc_q, ir_q, mar_q, mdr_q, y_q, inp_q, c_q;
    logic [63:0] z_q, z_d;
    logic [31:0] bus, mdr_d;
    logic [63:0] alu_res, rot;
    logic signed [31:0] sa, sb;
    logic [4:0]  sh;
    logic        unused_ok;

    assign rin  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                   R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign rout = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                   R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    dp_reg R0  (.clock, .clear, .en(rin[0]),  .d(bus), .q(r_q[0]));
    dp_reg R1  (.clock, .clear, .en(rin[1]),  .d(bus), .q(r_q[1]));
    dp_reg R2  (.clock, .clear, .en(rin[2]),  .d(bus), .q(r_q[2]));
    dp_reg R3  (.clock, .clear, .en(rin[3]),  .d(bus), .q(r_q[3]));
    dp_reg R4  (.clock, .clear, .en(rin[4]),  .d(bus), .q(r_q[4]));
    dp_reg R5  (.clock, .clear, .en(rin[5]),  .d(bus), .q(r_q[5]));
    dp_reg R6  (.clock, .clear, .en(rin[6]),  .d(bus), .q(r_q[6]));
    dp_reg R7  (.clock, .clear, .en(rin[7]),  .d(bus), .q(r_q[7]));
    dp_reg R8  (.clock, .clear, .en(rin[8]),  .d(bus), .q(r_q[8]));
    dp_reg R9  (.clock, .clear, .en(rin[9]),  .d(bus), .q(r_q[9]));
    dp_reg R10 (.clock, .clear, .en(rin[10]), .d(bus), .q(r_q[10]));
    dp_reg R11 (.clock, .clear, .en(rin[11]), .d(bus), .q(r_q[11]));
    dp_reg R12 (.clock, .clear, .en(rin[12]), .d(bus), .q(r_q[12]));
    dp_reg R13 (.clock, .clear, .en(rin[13]), .d(bus), .q(r_q[13]));
    dp_reg R14 (.clock, .clear, .en(rin[14]), .d(bus), .q(r_q[14]));
    dp_reg R15 (.clock, .clear, .en(rin[15]), .d(bus), .q(r_q[15]));

    dp_reg HI  (.clock, .clear, .en(HIin),      .d(bus),   .q(hi_q));
    dp_reg LO  (.clock, .clear, .en(LOin),      .d(bus),   .q(lo_q));
    dp_reg PC  (.clock, .clear, .en(PCin),      .d(bus),   .q(pc_q));
    dp_reg IR  (.clock, .clear, .en(IRin),      .d(bus),   .q(ir_q));
    dp_reg MAR (.clock, .clear, .en(MARin),     .d(bus),   .q(mar_q));
    dp_reg MDR (.clock, .clear, .en(MDRin),     .d(mdr_d), .q(mdr_q));
    dp_reg Y   (.clock, .clear, .en(Yin),       .d(bus),   .q(y_q));
    dp_reg INP (.clock, .clear, .en(In_Portin), .d(bus),   .q(inp_q));
    dp_reg C   (.clock, .clear, .en(Coutin),    .d(bus),   .q(c_q));

    // IR and MAR feed later-phase logic (decode, memory address) only.
    assign unused_ok = ^{ir_q, mar_q};

    assign mdr_d       = Read ? Mdatain : bus;
    assign Out_Portout = bus;

    // Bus priority encoder: lowest-priority source is assigned first so
    // each higher-priority strobe overrides it; R0 ends up on top.
    always_comb begin
        bus = '0;
        if (Coutout)    bus = c_q;
        if (In_Portout) bus = inp_q;
        if (MDRout)     bus = mdr_q;
        if (PCout)      bus = pc_q;
        if (Zlowout)    bus = z_q[31:0];
        if (Zhighout)   bus = z_q[63:32];
        if (LOout)      bus = lo_q;
        if (HIout)      bus = hi_q;
        for (int i = 15; i >= 0; i--)
            if (rout[i]) bus = r_q[i];
    end

    // ALU: A = Y, B = bus. IncPC overrides the opcode.
    always_comb begin
        sa      = y_q;
        sb      = bus;
        sh      = bus[4:0];
        rot     = '0;
        alu_res = '0;
        if (IncPC) begin
            alu_res = {32'b0, bus + 32'd1};
        end else begin
            case (ALU_Control)
                5'b00000: alu_res = {32'b0, y_q + bus};
                5'b00001: alu_res = {32'b0, y_q - bus};
                5'b00010: alu_res = {32'b0, y_q & bus};
                5'b00011: alu_res = {32'b0, y_q | bus};
                5'b00100: alu_res = {32'b0, y_q >> sh};
                5'b00101: alu_res = {32'b0, 32'(sa >>> sh)};
                5'b00110: alu_res = {32'b0, y_q << sh};
                5'b00111: begin
                    rot     = {y_q, y_q} >> sh;
                    alu_res = {32'b0, rot[31:0]};
                end
                5'b01000: begin
                    rot     = {y_q, y_q} << sh;
                    alu_res = {32'b0, rot[63:32]};
                end
                // Sign-extend both to 64 bits; low 64 bits of the product
                // equal the signed product.
                5'b01001: alu_res = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};
                5'b01010: begin
                    if (bus == 32'd0)
                        alu_res = {y_q, 32'hFFFF_FFFF};
                    else if (y_q == 32'h8000_0000 && bus == 32'hFFFF_FFFF)
                        alu_res = {32'd0, 32'h8000_0000};  // wraps, rem 0
                    else
                        alu_res = {32'(sa % sb), 32'(sa / sb)};
                end
                5'b01011: alu_res = {32'b0, 32'd0 - bus};
                5'b01100: alu_res = {32'b0, ~bus};
                default:  alu_res = '0;
            endcase
        end
    end

    // Z next state: full ALU capture wins over half-word bus loads.
    always_comb begin
        z_d = z_q;
        if (Zin) begin
            z_d = alu_res;
        end else begin
            if (Zhighin) z_d[63:32] = bus;
            if (Zlowin)  z_d[31:0]  = bus;
        end
    end

    // Z register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!clear) z_q <= '0;
        else        z_q <= z_d;
    end
endmodule

// File: tb/tb_datapath.sv
// Randomized + directed bench for datapath against an arithmetic reference model.
module tb_datapath;
    // Out-strobe bit indices (0..15 are R0..R15)
    localparam int O_HI = 16, O_LO = 17, O_ZH = 18, O_ZL = 19,
                   O_PC = 20, O_MDR = 21, O_INP = 22, O_C = 23;
    // In-strobe bit indices (0..15 are R0..R15)
    localparam int I_HI = 16, I_LO = 17, I_PC = 18, I_IR = 19, I_MAR = 20,
                   I_Y = 21, I_INP = 22, I_C = 23, I_ZH = 24, I_ZL = 25,
                   I_ZIN = 26, I_MDR = 27;

    logic        clock = 1'b0;
    logic        clear;
    logic [23:0] outs;
    logic [27:0] ins;
    logic        Read, IncPC;
    logic [31:0] Mdatain, Out_Portout;
    logic [4:0]  ALU_Control;

    int nchk = 0, nerr = 0;

    // Reference state
    bit [31:0] m_r [16];
    bit [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y, m_inp, m_c;
    bit [63:0] m_z;

    always #5 clock = ~clock;

    datapath DUT (
        .clock(clock), .clear(clear),
        .R0in(ins[0]), .R1in(ins[1]), .R2in(ins[2]), .R3in(ins[3]),
        .R4in(ins[4]), .R5in(ins[5]), .R6in(ins[6]), .R7in(ins[7]),
        .R8in(ins[8]), .R9in(ins[9]), .R10in(ins[10]), .R11in(ins[11]),
        .R12in(ins[12]), .R13in(ins[13]), .R14in(ins[14]), .R15in(ins[15]),
        .HIin(ins[I_HI]), .LOin(ins[I_LO]), .PCin(ins[I_PC]), .IRin(ins[I_IR]),
        .MARin(ins[I_MAR]), .Yin(ins[I_Y]), .In_Portin(ins[I_INP]), .Coutin(ins[I_C]),
        .Zhighin(ins[I_ZH]), .Zlowin(ins[I_ZL]), .Zin(ins[I_ZIN]), .MDRin(ins[I_MDR]),
        .Read(Read),
        .R0out(outs[0]), .R1out(outs[1]), .R2out(outs[2]), .R3out(outs[3]),
        .R4out(outs[4]), .R5out(outs[5]), .R6out(outs[6]), .R7out(outs[7]),
        .R8out(outs[8]), .R9out(outs[9]), .R10out(outs[10]), .R11out(outs[11]),
        .R12out(outs[12]), .R13out(outs[13]), .R14out(outs[14]), .R15out(outs[15]),
        .HIout(outs[O_HI]), .LOout(outs[O_LO]), .Zhighout(outs[O_ZH]),
        .Zlowout(outs[O_ZL]), .PCout(outs[O_PC]), .MDRout(outs[O_MDR]),
        .In_Portout(outs[O_INP]), .Coutout(outs[O_C]),
        .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
        .Out_Portout(Out_Portout)
    );

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [23:0] ob(int i); return 24'(1) << i; endfunction
    function automatic bit [27:0] ib(int i); return 28'(1) << i; endfunction

    function automatic void m_reset();
        foreach (m_r[i]) m_r[i] = '0;
        m_hi = 0; m_lo = 0; m_pc = 0; m_ir = 0; m_mar = 0;
        m_mdr = 0; m_y = 0; m_inp = 0; m_c = 0; m_z = 0;
    endfunction

    function automatic bit [31:0] m_src(int i);
        if (i < 16) return m_r[i];
        case (i)
            O_HI: return m_hi;        O_LO: return m_lo;
            O_ZH: return m_z[63:32];  O_ZL: return m_z[31:0];
            O_PC: return m_pc;        O_MDR: return m_mdr;
            O_INP: return m_inp;      default: return m_c;
        endcase
    endfunction

    // First asserted strobe in listed order wins; none -> 0.
    function automatic bit [31:0] m_bus(bit [23:0] o);
        for (int i = 0; i < 24; i++) if (o[i]) return m_src(i);
        return 0;
    endfunction

    function automatic bit [63:0] m_alu(bit [31:0] a, bit [31:0] b, bit [4:0] op, bit inc);
        int        sa = a, sb = b;
        int        s  = int'(b[4:0]);
        bit [31:0] t;
        longint    p;
        if (inc) return {32'b0, b + 32'd1};
        case (op)
            0:  t = a + b;
            1:  t = a - b;
            2:  t = a & b;
            3:  t = a | b;
            4:  t = a >> s;
            5:  t = sa >>> s;
            6:  t = a << s;
            7:  t = (a >> s) | (a << (32 - s));
            8:  t = (a << s) | (a >> (32 - s));
            9:  begin p = longint'(sa) * longint'(sb); return p; end
            10: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            11: t = -b;
            12: t = ~b;
            default: t = 0;
        endcase
        return {32'b0, t};
    endfunction

    // One control cycle: drive, check the bus, clock, update the model.
    task automatic step(bit [23:0] o, bit [27:0] in_, bit rd, bit [31:0] md,
                        bit [4:0] op, bit inc);
        bit [31:0] b;
        bit [63:0] res;
        @(negedge clock);
        outs = o; ins = in_; Read = rd; Mdatain = md; ALU_Control = op; IncPC = inc;
        #1;
        b = m_bus(o);
        chk("bus", Out_Portout, b);
        res = m_alu(m_y, b, op, inc);
        @(posedge clock);
        for (int i = 0; i < 16; i++) if (in_[i]) m_r[i] = b;
        if (in_[I_HI])  m_hi  = b;
        if (in_[I_LO])  m_lo  = b;
        if (in_[I_PC])  m_pc  = b;
        if (in_[I_IR])  m_ir  = b;
        if (in_[I_MAR]) m_mar = b;
        if (in_[I_Y])   m_y   = b;
        if (in_[I_INP]) m_inp = b;
        if (in_[I_C])   m_c   = b;
        if (in_[I_MDR]) m_mdr = rd ? md : b;
        if (in_[I_ZIN]) m_z = res;
        else begin
            if (in_[I_ZH]) m_z[63:32] = b;
            if (in_[I_ZL]) m_z[31:0]  = b;
        end
        #1; outs = '0; ins = '0; IncPC = 0;
    endtask

    task automatic do_reset(bit [23:0] o, bit [27:0] in_);
        @(negedge clock);
        clear = 0; outs = o; ins = in_; Mdatain = $urandom;
        @(posedge clock);
        #1; clear = 1; outs = '0; ins = '0;
        m_reset();
    endtask

    task automatic check_state();
        chk("R0", DUT.R0.q, m_r[0]);   chk("R5", DUT.R5.q, m_r[5]);
        chk("R15", DUT.R15.q, m_r[15]); chk("HI", DUT.HI.q, m_hi);
        chk("PC", DUT.PC.q, m_pc);     chk("MAR", DUT.MAR.q, m_mar);
        chk("IR", DUT.IR.q, m_ir);     chk("MDR", DUT.MDR.q, m_mdr);
        chk("Y", DUT.Y.q, m_y);        chk("Z", DUT.z_q, m_z);
    endtask

    // Load MDR from memory, then copy it to destination bit d.
    task automatic ld(bit [31:0] v, int d);
        step('0, ib(I_MDR), 1, v, 0, 0);
        step(ob(O_MDR), ib(d), 0, 0, 0, 0);
    endtask

    task automatic alu_op(bit [31:0] a, bit [31:0] b, bit [4:0] op);
        ld(a, I_Y);
        step('0, ib(I_MDR), 1, b, 0, 0);
        step(ob(O_MDR), ib(I_ZIN), 0, 0, op, 0);
    endtask

    initial begin
        clear = 0; outs = '0; ins = '0; Read = 0; IncPC = 0;
        Mdatain = '0; ALU_Control = '0;
        m_reset();
        repeat (2) @(posedge clock);
        #1; clear = 1;

        // Reset after arbitrary loads, with strobes active during clear
        for (int i = 0; i < 24; i++) ld($urandom, i);
        alu_op(32'h1234, 32'h77, 9);
        do_reset('1, '1);
        check_state();
        for (int i = 0; i < 24; i++) step(ob(i), '0, 0, 0, 0, 0);

        // Register loads
        ld(32'h34, 5); chk("R5_load", DUT.R5.q, 32'h34);
        ld(32'h45, 6); chk("R6_load", DUT.R6.q, 32'h45);

        // Fetch
        step(ob(O_PC), ib(I_MAR) | ib(I_ZIN), 0, 0, 0, 1);
        chk("fetch_MAR", DUT.MAR.q, 0); chk("fetch_Z", DUT.z_q, 64'd1);
        step(ob(O_ZL), ib(I_PC) | ib(I_MDR), 1, 32'h112B0000, 0, 0);
        chk("fetch_PC", DUT.PC.q, 1); chk("fetch_MDR", DUT.MDR.q, 32'h112B0000);
        step(ob(O_MDR), ib(I_IR), 0, 0, 0, 0);
        chk("fetch_IR", DUT.IR.q, 32'h112B0000);

        // AND R5,R6 -> R2
        step(ob(5), ib(I_Y), 0, 0, 0, 0);
        step(ob(6), ib(I_ZIN), 0, 0, 5'b00010, 0);
        step(ob(O_ZL), ib(2), 0, 0, 0, 0);
        chk("AND_R2", DUT.R2.q, 32'h4);

        // Arithmetic / shift corners
        alu_op(32'hFFFFFFFF, 1, 0);           chk("ADD_wrap", DUT.z_q, 64'h0);
        alu_op(32'hFFFFFFFE, 3, 9);           chk("MUL_neg", DUT.z_q, 64'hFFFFFFFFFFFFFFFA);
        alu_op(7, 32'hFFFFFFFE, 10);          chk("DIV", DUT.z_q, 64'h00000001_FFFFFFFD);
        alu_op(5, 0, 10);                     chk("DIV0", DUT.z_q, 64'h00000005_FFFFFFFF);
        alu_op(1, 1, 7);                      chk("ROR", DUT.z_q, 64'h80000000);
        alu_op(32'h80000000, 4, 5);           chk("SHRA", DUT.z_q, 64'hF8000000);
        alu_op(32'h80000001, 33, 8);          chk("ROL", DUT.z_q, 64'h3);
        alu_op(0, 5, 11);                     chk("NEG", DUT.z_q, 64'hFFFFFFFB);

        // Priority R1 over R3
        ld(32'h11, 1); ld(32'h33, 3);
        @(negedge clock); outs = ob(1) | ob(3); #1;
        chk("prio", Out_Portout, 32'h11);
        outs = '0;
        @(negedge clock); outs = ob(O_C) | ob(O_PC); #1;
        chk("prio_PC_C", Out_Portout, m_pc);
        outs = '0;

        // Self-transfer and Zin over Zhigh/Zlow
        step(ob(5), ib(5) | ib(I_Y), 0, 0, 0, 0);
        step(ob(O_MDR), ib(I_ZIN) | ib(I_ZH) | ib(I_ZL), 0, 0, 0, 0);
        check_state();

        // Random traffic with occasional mid-sequence reset
        for (int n = 0; n < 400; n++) begin
            bit [23:0] o;
            bit [27:0] in_;
            int        mode = $urandom_range(0, 3);
            o   = (mode == 0) ? '0 : (mode == 3) ? 24'($urandom) : ob($urandom_range(0, 23));
            in_ = 28'($urandom & $urandom & $urandom);
            if (n % 50 == 49) do_reset(o, in_);
            else step(o, in_, 1'($urandom), $urandom, 5'($urandom_range(0, 15)),
                      ($urandom_range(0, 7) == 0));
            check_state();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
